dsm_decimator: RTL and testbench

- Receive-side counterpart of dsm_top: reconstructs 14-bit signed samples from the 3-level pwm stream the modulator produces at the fast clock rate.
- Implemented as a 3rd-order CIC decimator (integrate at clock rate, comb at decimated rate) with output scaling and saturation.
- Sits after the modulator output in the loopback/verification path and feeds sample consumers at the slow rate.

---
 rtl/dsm_decimator.sv | 111 +++++++++++
 tb/tb_dsm_decimator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dsm_decimator.sv
// Third-order CIC decimator that rebuilds signed samples from the ternary pwm stream.
// Integrators run every clock; combs, scaling and saturation run once per R clocks.
module dsm_decimator #(
  parameter int DEC_LOG2 = 4,
  parameter int OUT_W    = 14
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              pwm,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  output logic                    err
);

  localparam int ACC_W = 3 * DEC_LOG2 + 2;
  localparam int SHIFT = OUT_W - 1 - 3 * DEC_LOG2;
  localparam int SW    = OUT_W + 1;

  logic [ACC_W-1:0] x;
  logic             illegal;

  logic [DEC_LOG2-1:0] cnt;
  logic [1:0]          warm;
  logic                dec_event;
  logic                res_ready;

  logic [ACC_W-1:0] i1, i2, i3;
  logic [ACC_W-1:0] z1, z2, z3;
  logic [ACC_W-1:0] d1, d2, d3;
  logic [ACC_W-1:0] res;

  logic [SW-1:0]    scaled;
  logic [OUT_W-1:0] sat_val;

  always_comb begin
    x       = '0;
    illegal = 1'b0;
    case (pwm)
      2'b01:   x = {{(ACC_W-1){1'b0}}, 1'b1};
      2'b11:   x = '1;
      2'b10:   illegal = 1'b1;
      default: x = '0;
    endcase
  end

  assign dec_event = (cnt == {DEC_LOG2{1'b1}});

  always_comb begin
    d1 = i3 - z1;
    d2 = d1 - z2;
    d3 = d2 - z3;
  end

  // Widen with sign extension before scaling so any overflow shows up in the top two bits.
  always_comb begin
    scaled  = {{(SW-ACC_W){res[ACC_W-1]}}, res} << SHIFT;
    sat_val = scaled[OUT_W-1:0];
    if (scaled[SW-1] != scaled[SW-2]) begin
      sat_val = scaled[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      i1  <= i1 + x;
      i2  <= i2 + i1;
      i3  <= i3 + i2;
      if (illegal) err <= 1'b1;
    end
  end

  // Comb section: results before the fourth event still carry start-up garbage, hence warm-up.
  always_ff @(posedge clock) begin
    if (!reset) begin
      z1        <= '0;
      z2        <= '0;
      z3        <= '0;
      res       <= '0;
      warm      <= '0;
      res_ready <= 1'b0;
    end else begin
      res_ready <= 1'b0;
      if (dec_event) begin
        z1        <= i3;
        z2        <= d1;
        z3        <= d2;
        res       <= d3;
        res_ready <= (warm == 2'd3);
        if (warm != 2'd3) warm <= warm + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= res_ready;
      if (res_ready) dout <= sat_val;
    end
  end

endmodule

// File: tb/tb_dsm_decimator.sv
// Directed bench for dsm_decimator: strobe timing, DC gain, saturation, err flag, reset abort.
module tb_dsm_decimator;

  logic               clock;
  logic               reset;
  logic [1:0]         pwm;
  logic signed [13:0] dout;
  logic               dout_valid;
  logic               err;

  logic [1:0] pat_a, pat_b;
  int pass_count = 0;
  int check_count = 0;

  dsm_decimator #(.DEC_LOG2(4), .OUT_W(14)) dut (
    .clock      (clock),
    .reset      (reset),
    .pwm        (pwm),
    .dout       (dout),
    .dout_valid (dout_valid),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b);
    pat_a = a;
    pat_b = b;
    pwm   = a;
  endtask

  // Outputs are sampled 1 time unit after the edge; pwm then advances along the a/b pattern.
  task automatic tick();
    @(posedge clock);
    #1;
    pwm = (pwm == pat_a) ? pat_b : pat_a;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  task automatic wait_strobe(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (dout_valid) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int e;
    int bad_val;
    int bad_int;

    reset = 1'b0;
    applyStimulus(2'b00, 2'b00);

    repeat (20) tick();
    checkOutput("reset_dout", dout, 0);
    checkOutput("reset_valid", dout_valid, 0);
    checkOutput("reset_err", err, 0);
    reset = 1'b1;

    wait_strobe(100, e);
    checkOutput("zero_first_strobe_edge", e, 65);
    checkOutput("zero_dout_1", dout, 0);
    checkOutput("zero_err", err, 0);
    tick();
    checkOutput("zero_strobe_one_cycle", dout_valid, 0);
    wait_strobe(16, e);
    checkOutput("zero_interval_1", e, 15);
    wait_strobe(16, e);
    checkOutput("zero_interval_2", e, 16);
    checkOutput("zero_dout_3", dout, 0);

    applyStimulus(2'b01, 2'b01);
    do_reset(2);
    wait_strobe(100, e);
    checkOutput("pos_first_strobe_edge", e, 65);
    checkOutput("pos_first_dout", dout, 8191);
    tick();
    checkOutput("pos_dout_hold", dout, 8191);
    bad_val = 0;
    bad_int = 0;
    wait_strobe(16, e);
    if (e != 15) bad_int++;
    if (dout != 14'sd8191) bad_val++;
    for (int k = 0; k < 1000; k++) begin
      wait_strobe(16, e);
      if (e != 16) bad_int++;
      if (dout != 14'sd8191) bad_val++;
    end
    checkOutput("pos_wrap_bad_values", bad_val, 0);
    checkOutput("pos_wrap_bad_intervals", bad_int, 0);

    applyStimulus(2'b11, 2'b11);
    do_reset(2);
    wait_strobe(100, e);
    checkOutput("neg_first_strobe_edge", e, 65);
    for (int k = 2; k <= 4; k++) begin
      wait_strobe(16, e);
      checkOutput($sformatf("neg_dout_strobe%0d", k), dout, -8192);
    end

    applyStimulus(2'b01, 2'b00);
    do_reset(2);
    wait_strobe(100, e);
    for (int k = 2; k <= 4; k++) begin
      wait_strobe(16, e);
      checkOutput($sformatf("half_dout_strobe%0d", k), dout, 4096);
    end

    applyStimulus(2'b01, 2'b11);
    do_reset(2);
    wait_strobe(100, e);
    for (int k = 2; k <= 4; k++) begin
      wait_strobe(16, e);
      checkOutput($sformatf("alt_dout_strobe%0d", k), dout, 0);
    end

    applyStimulus(2'b00, 2'b00);
    do_reset(2);
    repeat (30) tick();
    checkOutput("err_before_inject", err, 0);
    pwm = 2'b10;
    tick();
    checkOutput("err_after_inject", err, 1);
    wait_strobe(100, e);
    checkOutput("err_strobe_edge", e, 34);
    checkOutput("err_dout", dout, 0);
    wait_strobe(16, e);
    checkOutput("err_sticky", err, 1);
    checkOutput("err_dout_2", dout, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("err_cleared", err, 0);

    applyStimulus(2'b01, 2'b01);
    do_reset(2);
    wait_strobe(100, e);
    checkOutput("abort_first_strobe_edge", e, 65);
    repeat (15) tick();
    checkOutput("abort_dout_before", dout, 8191);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("abort_dout", dout, 0);
    checkOutput("abort_valid", dout_valid, 0);
    wait_strobe(100, e);
    checkOutput("abort_next_strobe_edge", e, 65);
    checkOutput("abort_next_dout", dout, 8191);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
